// File: rtl/seqdet_pkg.sv
// seqdet_pkg: default pattern constants plus length-mask and length-clamp helpers for seq_detector_param
package seqdet_pkg;
  localparam int PAT_W_D = 8;
  localparam int LEN_W = $clog2(PAT_W_D + 1);
  localparam logic [PAT_W_D-1:0] DEF_PAT = 8'b0000_0101;
  localparam int DEF_LEN = 3;
  function automatic logic [31:0] len_mask(input int unsigned l);
    return (l >= 32) ? '1 : (32'd1 << l) - 32'd1;
  endfunction
  function automatic int unsigned clamp_len(input int unsigned l, input int unsigned maxw);
    return (l == 0) ? 1 : (l > maxw) ? maxw : l;
  endfunction
endpackage

// File: rtl/seqdet_sat_cnt.sv
// seqdet_sat_cnt: W-bit saturating counter (clk, rst async, inc, clr sync with clr+inc giving 1, cnt out)
module seqdet_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= W'(inc);
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: configurable serial pattern detector (x_valid/x in, cfg_we/cfg_pat/cfg_len/cfg_overlap load, cnt_clr, registered y pulse, saturating match_count)
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seqdet_pkg::DEF_PAT),
  parameter int DEF_LEN = seqdet_pkg::DEF_LEN,
  localparam int LW = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);
  logic [PAT_W-1:0] hist, pat, hist_n, mask;
  logic [LW-1:0] fill, len, fill_n;
  logic ovl, match;
  always_comb begin
    hist_n = {hist[PAT_W-2:0], x};
    fill_n = (fill == LW'(PAT_W)) ? fill : fill + 1'b1;
    mask = PAT_W'(len_mask(32'(len)));
    match = x_valid && !cfg_we && fill_n >= len && ((hist_n ^ pat) & mask) == '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pat <= DEF_PAT;
      len <= LW'(DEF_LEN);
      ovl <= 1'b1;
      hist <= '0;
      fill <= '0;
      y <= 1'b0;
    end else if (cfg_we) begin
      pat <= cfg_pat;
      len <= LW'(clamp_len(32'(cfg_len), 32'(PAT_W)));
      ovl <= cfg_overlap;
      hist <= '0;
      fill <= '0;
      y <= 1'b0;
    end else if (x_valid) begin
      hist <= hist_n;
      fill <= (match && !ovl) ? '0 : fill_n;
      y <= match;
    end else y <= 1'b0;
  seqdet_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(match),
    .clr(cnt_clr),
    .cnt(match_count)
  );
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed stimulus with hand-derived y expectations checked through a scoreboard queue
module tb_seq_detector_param;
  logic clk = 0, rst = 1, x_valid = 0, x = 0, cfg_we = 0, cfg_overlap = 0, cnt_clr = 0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
  logic y;
  logic [7:0] match_count;
  typedef struct {string nm; logic ey; logic [7:0] ec;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0, exp_cnt = 0;
  always #5 clk = ~clk;
  seq_detector_param dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .y(y), .match_count(match_count)
  );
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (y !== e.ey) begin
        fails++;
        $display("FAIL %s y: got %0b expected %0b", e.nm, y, e.ey);
      end
      checks++;
      if (match_count !== e.ec) begin
        fails++;
        $display("FAIL %s match_count: got %0d expected %0d", e.nm, match_count, e.ec);
      end
    end
  end
  task automatic push(input string nm, input bit ey);
    exp_t e;
    e.nm = nm;
    e.ey = ey;
    e.ec = 8'(exp_cnt);
    q.push_back(e);
  endtask
  task automatic drv(input bit v, input bit b, input bit clr, input bit ey, input string nm);
    @(negedge clk);
    x_valid = v;
    x = b;
    cnt_clr = clr;
    cfg_we = 0;
    @(posedge clk);
    if (clr) exp_cnt = ey ? 1 : 0;
    else if (ey && exp_cnt < 255) exp_cnt++;
    push(nm, ey);
  endtask
  task automatic bitx(input bit b, input bit ey, input string nm);
    drv(1, b, 0, ey, nm);
  endtask
  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input bit o, input string nm);
    @(negedge clk);
    cfg_we = 1;
    cfg_pat = p;
    cfg_len = l;
    cfg_overlap = o;
    x_valid = 1;
    x = 1;
    cnt_clr = 0;
    @(posedge clk);
    push(nm, 0);
    @(negedge clk);
    cfg_we = 0;
    x_valid = 0;
  endtask
  task automatic do_rst(input string nm);
    @(negedge clk);
    rst = 1;
    x_valid = 0;
    cfg_we = 0;
    cnt_clr = 0;
    @(posedge clk);
    exp_cnt = 0;
    push(nm, 0);
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] a5;
    bit s1[11];
    bit e1[11];
    a5 = 8'hA5;
    s1 = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
    e1 = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    do_rst("reset");
    drv(0, 0, 0, 0, "idle_after_reset");
    for (int i = 0; i < 11; i++) bitx(s1[i], e1[i], $sformatf("def101_bit%0d", i + 1));
    cfg(8'b11, 2, 0, "cfg11_novl");
    bitx(1, 0, "11n_b1"); bitx(1, 1, "11n_b2"); bitx(1, 0, "11n_b3"); bitx(1, 1, "11n_b4");
    cfg(8'b11, 2, 1, "cfg11_ovl");
    bitx(1, 0, "11o_b1"); bitx(1, 1, "11o_b2"); bitx(1, 1, "11o_b3"); bitx(1, 1, "11o_b4");
    cfg(8'b101, 3, 1, "cfg101");
    bitx(1, 0, "bub_b1");
    repeat (3) drv(0, 1, 0, 0, "bubble_a");
    bitx(0, 0, "bub_b2");
    repeat (3) drv(0, 1, 0, 0, "bubble_b");
    bitx(1, 1, "bub_b3");
    drv(0, 1, 0, 0, "bubble_after");
    cfg(8'hA5, 8, 0, "cfgA5");
    for (int i = 7; i >= 0; i--) bitx(a5[i], i == 0, $sformatf("a5_bit%0d", 8 - i));
    cfg(8'h01, 0, 1, "cfg_len0");
    bitx(1, 1, "len0_b1"); bitx(0, 0, "len0_b2"); bitx(1, 1, "len0_b3");
    cfg(8'hA5, 15, 1, "cfg_len15");
    for (int i = 7; i >= 0; i--) bitx(a5[i], i == 0, $sformatf("len15_bit%0d", 8 - i));
    cfg(8'h01, 1, 1, "cfg_sat");
    for (int i = 0; i < 260; i++) bitx(1, 1, "sat");
    drv(0, 0, 1, 0, "clr_alone");
    drv(1, 1, 1, 1, "clr_with_match");
    bitx(1, 1, "after_clr");
    cfg(8'b101, 3, 1, "cfg101_rst");
    bitx(1, 0, "pre_rst_b1"); bitx(0, 0, "pre_rst_b2");
    do_rst("mid_rst");
    bitx(1, 0, "post_rst_tail");
    bitx(1, 0, "full_b1"); bitx(0, 0, "full_b2"); bitx(1, 1, "full_b3");
    bitx(1, 0, "pre_cfg_b1"); bitx(0, 0, "pre_cfg_b2");
    cfg(8'b101, 3, 1, "cfg_mid");
    bitx(1, 0, "post_cfg_b1"); bitx(0, 0, "post_cfg_b2"); bitx(1, 1, "post_cfg_b3");
    drv(0, 0, 0, 0, "final_idle");
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
